imem_pipe: RTL and testbench

Pipelined, parametrised instruction memory that replaces the single-cycle fetch model for the 16-bit RISC core. Fetch requests and instruction responses use valid/ready handshakes with a configurable read latency. A credit-limited response FIFO absorbs CPU back-pressure, and a flush input discards wrong-path fetches. A synchronous write port lets the testbench or a boot loader load the program, replacing the backdoor tasks.

---
 rtl/imem_if.sv | 30 +++
 rtl/imem_pipe.sv | 149 ++++++++++++++
 tb/tb_imem_pipe.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_if.sv
// Fetch, response and write-port signal bundle for imem_pipe.
// The master side is the CPU / boot loader; the slave side is the memory.
interface imem_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_instr;
  logic [ADDR_WIDTH-1:0] rsp_addr;
  logic                  rsp_perr;
  logic                  flush;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_par_flip;

  modport master (
    output req_valid, req_addr, rsp_ready, flush, wr_en, wr_addr, wr_data, wr_par_flip,
    input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_perr
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, flush, wr_en, wr_addr, wr_data, wr_par_flip,
    output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_perr
  );
endinterface

// File: rtl/imem_pipe.sv
// Pipelined instruction memory with credit-limited response FIFO and flush.
// Optional word parity storage/check is enabled by defining IMEM_PARITY_EN.
module imem_pipe #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int READ_LAT   = 2,
  parameter int RESP_DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  imem_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int PTR_W = $clog2(RESP_DEPTH);
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
`ifdef IMEM_PARITY_EN
  localparam int MEM_W = DATA_WIDTH + 1;
`else
  localparam int MEM_W = DATA_WIDTH;
`endif

  function automatic logic parity_f(input logic [DATA_WIDTH-1:0] d);
    return ^d;
  endfunction

  logic [MEM_W-1:0]      mem_r [DEPTH];
  logic [MEM_W-1:0]      wr_word_s;
  logic                  accept_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  perr_s;
  logic                  fifo_empty_s;
  logic [CNT_W-1:0]      cnt_r;
  logic [READ_LAT-1:0]   stg_vld_r;
  logic [ADDR_WIDTH-1:0] stg_addr_r [READ_LAT];
  logic [MEM_W-1:0]      stg_data_r [READ_LAT];
  logic [DATA_WIDTH-1:0] fifo_data_r [RESP_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr_r [RESP_DEPTH];
  logic [RESP_DEPTH-1:0] fifo_perr_r;
  logic [PTR_W:0]        wr_ptr_r;
  logic [PTR_W:0]        rd_ptr_r;

  // Credit check: cnt covers in-flight plus queued, so the FIFO can never overflow.
  assign bus.req_ready = rst & (cnt_r < CNT_W'(RESP_DEPTH)) & ~bus.flush;
  assign accept_s      = bus.req_valid & bus.req_ready;
  assign fifo_empty_s  = (wr_ptr_r == rd_ptr_r);
  assign bus.rsp_valid = ~fifo_empty_s;
  assign pop_s         = ~fifo_empty_s & bus.rsp_ready & ~bus.flush;
  assign push_s        = stg_vld_r[READ_LAT-1] & ~bus.flush;

  // Word stored into the array, with parity bit when enabled.
  always_comb begin
`ifdef IMEM_PARITY_EN
    wr_word_s = {parity_f(bus.wr_data) ^ bus.wr_par_flip, bus.wr_data};
`else
    wr_word_s = bus.wr_data;
`endif
  end

  // Parity check on the last pipeline stage.
  always_comb begin
`ifdef IMEM_PARITY_EN
    perr_s = stg_data_r[READ_LAT-1][DATA_WIDTH] ^ parity_f(stg_data_r[READ_LAT-1][DATA_WIDTH-1:0]);
`else
    perr_s = 1'b0;
`endif
  end

  // Memory array write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      mem_r[bus.wr_addr] <= wr_word_s;
    end
  end

  // Read pipeline: array is read at the accept edge (old data on a same-edge write).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stg_vld_r <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        stg_addr_r[i] <= '0;
        stg_data_r[i] <= '0;
      end
    end else begin
      stg_vld_r[0]  <= accept_s;
      stg_addr_r[0] <= bus.req_addr;
      stg_data_r[0] <= mem_r[bus.req_addr];
      for (int i = 1; i < READ_LAT; i++) begin
        stg_vld_r[i]  <= stg_vld_r[i-1] & ~bus.flush;
        stg_addr_r[i] <= stg_addr_r[i-1];
        stg_data_r[i] <= stg_data_r[i-1];
      end
    end
  end

  // Response FIFO storage and pointers; flush empties it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      fifo_perr_r <= '0;
      for (int i = 0; i < RESP_DEPTH; i++) begin
        fifo_data_r[i] <= '0;
        fifo_addr_r[i] <= '0;
      end
    end else if (bus.flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) begin
        fifo_data_r[wr_ptr_r[PTR_W-1:0]] <= stg_data_r[READ_LAT-1][DATA_WIDTH-1:0];
        fifo_addr_r[wr_ptr_r[PTR_W-1:0]] <= stg_addr_r[READ_LAT-1];
        fifo_perr_r[wr_ptr_r[PTR_W-1:0]] <= perr_s;
        wr_ptr_r <= wr_ptr_r + {{PTR_W{1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{PTR_W{1'b0}}, 1'b1};
      end
    end
  end

  // Credit counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (bus.flush) begin
      cnt_r <= '0;
    end else begin
      case ({accept_s, pop_s})
        2'b10:   cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01:   cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Head outputs read as zero whenever the FIFO is empty.
  always_comb begin
    if (fifo_empty_s) begin
      bus.rsp_instr = '0;
      bus.rsp_addr  = '0;
      bus.rsp_perr  = 1'b0;
    end else begin
      bus.rsp_instr = fifo_data_r[rd_ptr_r[PTR_W-1:0]];
      bus.rsp_addr  = fifo_addr_r[rd_ptr_r[PTR_W-1:0]];
      bus.rsp_perr  = fifo_perr_r[rd_ptr_r[PTR_W-1:0]];
    end
  end
endmodule

// File: tb/tb_imem_pipe.sv
// Bench for imem_pipe: table-driven latency vectors, directed corner sequences
// and random traffic checked against a queue-based response model.
`timescale 1ns/1ps
module tb_imem_pipe;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int RL = 2;
  localparam int RD = 4;
`ifdef IMEM_PARITY_EN
  localparam logic PAR_ON = 1'b1;
`else
  localparam logic PAR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  imem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  imem_pipe #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LAT(RL), .RESP_DEPTH(RD)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          perr;
    int            t;
  } ent_t;

  typedef struct {
    logic          rv;
    logic [AW-1:0] ra;
    logic          e_vld;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_instr;
  } vec_t;

  ent_t          q[$];
  logic [DW-1:0] mem_m [int];
  logic          flip_m [int];
  logic [DW-1:0] got_d[$];
  logic [AW-1:0] got_a[$];
  logic          got_p[$];
  int            n_chk = 0;
  int            n_fail = 0;
  int            cyc_n = 0;
  logic          obs_rdy, obs_vld;
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_instr;
  logic          acc;
  int            idx;
  int            n_acc;
  vec_t          tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic cyc(input logic rv, input logic [AW-1:0] ra, input logic rr, input logic fl,
                     input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                     input logic wf, output logic acc_o);
    logic exp_rdy, exp_vld, pop;
    ent_t e;
    bus.req_valid = rv;  bus.req_addr = ra;  bus.rsp_ready = rr;  bus.flush = fl;
    bus.wr_en = we;      bus.wr_addr = wa;   bus.wr_data = wd;    bus.wr_par_flip = wf;
    @(negedge clk);
    obs_rdy = bus.req_ready;  obs_vld = bus.rsp_valid;
    obs_addr = bus.rsp_addr;  obs_instr = bus.rsp_instr;
    exp_rdy = (q.size() < RD) && !fl;
    exp_vld = (q.size() > 0) && (q[0].t <= cyc_n);
    chk("req_ready", obs_rdy, exp_rdy);
    chk("rsp_valid", obs_vld, exp_vld);
    if (exp_vld && obs_vld) begin
      chk("rsp_addr", obs_addr, q[0].addr);
      chk("rsp_instr", obs_instr, q[0].data);
      chk("rsp_perr", bus.rsp_perr, q[0].perr);
    end
    acc_o = rv && obs_rdy;
    pop = exp_vld && rr && !fl;
    if (pop) begin
      got_d.push_back(obs_instr);
      got_a.push_back(obs_addr);
      got_p.push_back(bus.rsp_perr);
    end
    if (fl) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (rv && exp_rdy) begin
        e.addr = ra;
        e.data = mem_m[int'(ra)];
        e.perr = PAR_ON & flip_m[int'(ra)];
        e.t    = cyc_n + RL + 1;
        q.push_back(e);
      end
    end
    if (we) begin
      mem_m[int'(wa)]  = wd;
      flip_m[int'(wa)] = wf;
    end
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic idle(input logic rr);
    logic a;
    cyc(1'b0, '0, rr, 1'b0, 1'b0, '0, '0, 1'b0, a);
  endtask

  task automatic clear_got();
    got_d.delete();
    got_a.delete();
    got_p.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;  bus.req_addr = '0;  bus.rsp_ready = 1'b0;  bus.flush = 1'b0;
    bus.wr_en = 1'b0;      bus.wr_addr = '0;   bus.wr_data = '0;      bus.wr_par_flip = 1'b0;

    // Reset values while rst is held low.
    #12;
    chk("rst_req_ready", bus.req_ready, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_instr", bus.rsp_instr, 32'h0);
    chk("rst_rsp_addr", bus.rsp_addr, 12'h0);
    chk("rst_rsp_perr", bus.rsp_perr, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Load 0..7 with the latency pattern and 8..31 with random words.
    for (int i = 0; i < 32; i++) begin
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b1, AW'(i),
          (i < 8) ? (32'h1000_0000 + 32'(i)) : $urandom, 1'b0, acc);
    end

    // Latency / throughput vectors.
    for (int k = 0; k < 12; k++) begin
      tbl[k].rv      = (k < 8);
      tbl[k].ra      = AW'(k);
      tbl[k].e_vld   = (k >= 3) && (k <= 10);
      tbl[k].e_addr  = tbl[k].e_vld ? AW'(k - 3) : '0;
      tbl[k].e_instr = tbl[k].e_vld ? (32'h1000_0000 + 32'(k - 3)) : 32'h0;
    end
    for (int k = 0; k < 12; k++) begin
      cyc(tbl[k].rv, tbl[k].ra, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, acc);
      chk("tbl_ready", obs_rdy, 1'b1);
      chk("tbl_valid", obs_vld, tbl[k].e_vld);
      if (tbl[k].e_vld) begin
        chk("tbl_addr", obs_addr, tbl[k].e_addr);
        chk("tbl_instr", obs_instr, tbl[k].e_instr);
      end
    end

    // Back-pressure: six requests, only four accepted, then drain and finish.
    clear_got();
    idx = 0;
    n_acc = 0;
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, AW'(20 + idx), 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, acc);
      if (acc) begin idx++; n_acc++; end
    end
    chk("bp_accepted", n_acc, 4);
    chk("bp_ready_low", obs_rdy, 1'b0);
    for (int k = 0; k < 40 && !(idx == 6 && q.size() == 0); k++) begin
      cyc(idx < 6, AW'(20 + idx), 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, acc);
      if (acc) idx++;
    end
    chk("bp_drained", got_a.size(), 6);
    for (int i = 0; i < 6 && i < got_a.size(); i++) chk("bp_order", got_a[i], 20 + i);

    // Flush with two queued and two in flight.
    clear_got();
    for (int k = 0; k < 4; k++) cyc(1'b1, AW'(12 + k), 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, acc);
    cyc(1'b1, AW'(16), 1'b1, 1'b1, 1'b0, '0, '0, 1'b0, acc);
    chk("flush_ready", obs_rdy, 1'b0);
    chk("flush_head_valid", obs_vld, 1'b1);
    idle(1'b1);
    chk("flush_empty", obs_vld, 1'b0);
    cyc(1'b1, AW'(5), 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, acc);
    for (int k = 0; k < 8; k++) idle(1'b1);
    chk("flush_count", got_d.size(), 1);
    if (got_d.size() > 0) chk("flush_data", got_d[0], 32'h1000_0005);

    // Write collision: same-edge read returns old data.
    clear_got();
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1, AW'(9), 32'hA5A5_0009, 1'b0, acc);
    cyc(1'b1, AW'(9), 1'b1, 1'b0, 1'b1, AW'(9), 32'h5A5A_0009, 1'b0, acc);
    cyc(1'b1, AW'(9), 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, acc);
    for (int k = 0; k < 6; k++) idle(1'b1);
    chk("coll_count", got_d.size(), 2);
    if (got_d.size() > 1) begin
      chk("coll_old", got_d[0], 32'hA5A5_0009);
      chk("coll_new", got_d[1], 32'h5A5A_0009);
    end

    // Parity error injection.
    clear_got();
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1, AW'(16), 32'h0BAD_F00D, 1'b1, acc);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1, AW'(17), 32'h600D_CAFE, 1'b0, acc);
    cyc(1'b1, AW'(16), 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, acc);
    cyc(1'b1, AW'(17), 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, acc);
    for (int k = 0; k < 6; k++) idle(1'b1);
    chk("par_count", got_d.size(), 2);
    if (got_d.size() > 1) begin
      chk("par_perr_flip", got_p[0], PAR_ON);
      chk("par_perr_ok", got_p[1], 1'b0);
      chk("par_data0", got_d[0], 32'h0BAD_F00D);
      chk("par_data1", got_d[1], 32'h600D_CAFE);
    end

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      cyc(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)),
          $urandom, ($urandom_range(0, 7) == 0), acc);
    end

    // Asynchronous reset with three queued entries.
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0, acc);
    for (int k = 0; k < 3; k++) cyc(1'b1, AW'(k), 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, acc);
    for (int k = 0; k < 3; k++) idle(1'b0);
    chk("pre_rst_valid", bus.rsp_valid, 1'b1);
    rst = 1'b0;
    #1;
    chk("arst_req_ready", bus.req_ready, 1'b0);
    chk("arst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("arst_rsp_instr", bus.rsp_instr, 32'h0);
    chk("arst_rsp_addr", bus.rsp_addr, 12'h0);
    chk("arst_rsp_perr", bus.rsp_perr, 1'b0);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(1'b1);
    chk("post_rst_ready", obs_rdy, 1'b1);
    chk("post_rst_valid", obs_vld, 1'b0);
    for (int k = 0; k < 4; k++) idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
